// File: rtl/sfu_exp_pipe.sv
// Multi-lane pipelined exponential unit: per lane e^(x - lnF) ~= 2^u * (1 + v + d),
// three register stages (align/subtract, log2e scale, split/normalise/clamp) with back-pressure.
module sfu_exp_pipe #(
    parameter int unsigned LANES  = 4,
    parameter int unsigned IN_W   = 16,
    parameter int unsigned LNF_W  = 16,
    parameter int unsigned TMP_W  = 32,
    parameter int unsigned D_W    = 16,
    parameter int unsigned FRAC_W = 12,
    parameter int unsigned OUT_W  = 16,
    parameter int unsigned EXP_W  = 6,
    parameter int unsigned TAG_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  data_in,
    input  logic [4:0]             data_in_Q,
    input  logic                   lnF_en,
    input  logic [LNF_W-1:0]       lnF_in,
    input  logic [4:0]             lnF_in_Q,
    input  logic [D_W-1:0]         d_in,
    input  logic [TAG_W-1:0]       tag_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] mant_out,
    output logic [LANES*EXP_W-1:0] exp_out,
    output logic [LANES-1:0]       sat_out,
    output logic [TAG_W-1:0]       tag_out
);
    localparam int unsigned Q_W  = 5;
    localparam int unsigned SH_W = Q_W + 1;
    localparam logic [SH_W-1:0] FRAC_SH = SH_W'(FRAC_W);

    localparam logic signed [TMP_W-1:0] ONE_M    = TMP_W'(1) << FRAC_W;
    localparam logic signed [TMP_W-1:0] MANT_MAX = TMP_W'((64'd1 << OUT_W) - 64'd1);
    localparam logic signed [TMP_W-1:0] EXP_MAX  = TMP_W'((64'd1 << (EXP_W - 1)) - 64'd1);
    localparam logic signed [TMP_W-1:0] EXP_MIN  = -EXP_MAX - TMP_W'(1);

    logic                   en;
    logic                   s1_vld_q, s2_vld_q, s3_vld_q;
    logic [LANES*TMP_W-1:0] s1_t_d, s1_t_q, s2_s_d, s2_s_q;
    logic [Q_W-1:0]         s1_q_d, s1_q_q, s2_q_q;
    logic [D_W-1:0]         s1_dd_q, s2_dd_q;
    logic [TAG_W-1:0]       s1_tag_q, s2_tag_q, s3_tag_q;
    logic [LANES*OUT_W-1:0] s3_mant_d, s3_mant_q;
    logic [LANES*EXP_W-1:0] s3_exp_d, s3_exp_q;
    logic [LANES-1:0]       s3_sat_d, s3_sat_q;

    // Single global enable: the whole pipe advances only when the output slot can move.
    assign en       = ~s3_vld_q | out_ready;
    assign in_ready = en;

    // S1: bring x and lnF to a common binary point, then subtract.
    always_comb begin
        logic [Q_W-1:0]          sh_x, sh_l;
        logic signed [TMP_W-1:0] lnf_ext, x_ext;
        s1_t_d  = '0;
        s1_q_d  = data_in_Q;
        sh_x    = '0;
        sh_l    = '0;
        x_ext   = '0;
        if (lnF_en) begin
            s1_q_d = (lnF_in_Q > data_in_Q) ? lnF_in_Q : data_in_Q;
            sh_x   = s1_q_d - data_in_Q;
            sh_l   = s1_q_d - lnF_in_Q;
        end
        lnf_ext = TMP_W'($signed(lnF_in)) <<< sh_l;
        for (int l = 0; l < LANES; l++) begin
            x_ext = TMP_W'($signed(data_in[l*IN_W +: IN_W])) <<< sh_x;
            s1_t_d[l*TMP_W +: TMP_W] = lnF_en ? (x_ext - lnf_ext) : x_ext;
        end
    end

    // S2: multiply by log2e ~= 1 + 1/2 - 1/16.
    always_comb begin
        logic signed [TMP_W-1:0] t;
        s2_s_d = '0;
        t      = '0;
        for (int l = 0; l < LANES; l++) begin
            t = $signed(s1_t_q[l*TMP_W +: TMP_W]);
            s2_s_d[l*TMP_W +: TMP_W] = t + (t >>> 1) - (t >>> 4);
        end
    end

    // S3: split into integer exponent and fraction, rebase fraction to FRAC_W, clamp.
    always_comb begin
        logic signed [TMP_W-1:0] s, u, v, vf, m, d_ext, u_c, m_c;
        logic                    sat_e, sat_m;
        s3_mant_d = '0;
        s3_exp_d  = '0;
        s3_sat_d  = '0;
        s = '0; u = '0; v = '0; vf = '0; m = '0; u_c = '0; m_c = '0;
        sat_e = 1'b0;
        sat_m = 1'b0;
        d_ext = TMP_W'($signed(s2_dd_q));
        for (int l = 0; l < LANES; l++) begin
            s = $signed(s2_s_q[l*TMP_W +: TMP_W]);
            u = s >>> s2_q_q;
            v = s - (u <<< s2_q_q);
            if ({1'b0, s2_q_q} >= FRAC_SH) begin
                vf = v >> ({1'b0, s2_q_q} - FRAC_SH);
            end else begin
                vf = v << (FRAC_SH - {1'b0, s2_q_q});
            end
            m = ONE_M + vf + d_ext;

            sat_e = 1'b1;
            if (u > EXP_MAX) begin
                u_c = EXP_MAX;
            end else if (u < EXP_MIN) begin
                u_c = EXP_MIN;
            end else begin
                u_c   = u;
                sat_e = 1'b0;
            end

            sat_m = 1'b1;
            if (m[TMP_W-1]) begin
                m_c = '0;
            end else if (m > MANT_MAX) begin
                m_c = MANT_MAX;
            end else begin
                m_c   = m;
                sat_m = 1'b0;
            end

            s3_exp_d[l*EXP_W +: EXP_W]  = EXP_W'(u_c);
            s3_mant_d[l*OUT_W +: OUT_W] = OUT_W'(m_c);
            s3_sat_d[l]                 = sat_e | sat_m;
        end
    end

    // Valids honour flush unconditionally; data and control move with the global enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            s1_t_q    <= '0;
            s1_q_q    <= '0;
            s1_dd_q   <= '0;
            s1_tag_q  <= '0;
            s2_s_q    <= '0;
            s2_q_q    <= '0;
            s2_dd_q   <= '0;
            s2_tag_q  <= '0;
            s3_mant_q <= '0;
            s3_exp_q  <= '0;
            s3_sat_q  <= '0;
            s3_tag_q  <= '0;
        end else begin
            if (flush) begin
                s1_vld_q <= 1'b0;
                s2_vld_q <= 1'b0;
                s3_vld_q <= 1'b0;
            end else if (en) begin
                s1_vld_q <= in_valid;
                s2_vld_q <= s1_vld_q;
                s3_vld_q <= s2_vld_q;
            end
            if (en) begin
                s1_t_q    <= s1_t_d;
                s1_q_q    <= s1_q_d;
                s1_dd_q   <= d_in;
                s1_tag_q  <= tag_in;
                s2_s_q    <= s2_s_d;
                s2_q_q    <= s1_q_q;
                s2_dd_q   <= s1_dd_q;
                s2_tag_q  <= s1_tag_q;
                s3_mant_q <= s3_mant_d;
                s3_exp_q  <= s3_exp_d;
                s3_sat_q  <= s3_sat_d;
                s3_tag_q  <= s2_tag_q;
            end
        end
    end

    assign out_valid = s3_vld_q;
    assign mant_out  = s3_mant_q;
    assign exp_out   = s3_exp_q;
    assign sat_out   = s3_sat_q;
    assign tag_out   = s3_tag_q;

endmodule

// File: tb/tb_sfu_exp_pipe.sv
// Directed bench for sfu_exp_pipe: vector table through the pipe, then stall,
// flush and mid-stream reset sequences.
`timescale 1ns/1ps
module tb_sfu_exp_pipe;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, lnF_en, out_valid, out_ready;
    logic [63:0] data_in;
    logic [4:0]  data_in_Q, lnF_in_Q;
    logic [15:0] lnF_in, d_in;
    logic [3:0]  tag_in, tag_out, sat_out;
    logic [63:0] mant_out;
    logic [23:0] exp_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sfu_exp_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .data_in_Q(data_in_Q), .lnF_en(lnF_en), .lnF_in(lnF_in),
        .lnF_in_Q(lnF_in_Q), .d_in(d_in), .tag_in(tag_in), .out_valid(out_valid),
        .out_ready(out_ready), .mant_out(mant_out), .exp_out(exp_out), .sat_out(sat_out),
        .tag_out(tag_out)
    );

    typedef struct packed {
        logic [63:0] x;
        logic [4:0]  dq;
        logic        lnf_en;
        logic [15:0] lnf;
        logic [4:0]  lq;
        logic [15:0] d;
        logic [3:0]  tag;
        logic [63:0] mant;
        logic [23:0] ex;
        logic [3:0]  sat;
    } vec_t;

    vec_t vecs [9];

    function automatic vec_t mk(input logic [63:0] x, input logic [4:0] dq, input logic le,
                                input logic [15:0] lnf, input logic [4:0] lq, input logic [15:0] d,
                                input logic [3:0] tag, input logic [63:0] mant,
                                input logic [23:0] ex, input logic [3:0] sat);
        vec_t v;
        v.x = x; v.dq = dq; v.lnf_en = le; v.lnf = lnf; v.lq = lq; v.d = d;
        v.tag = tag; v.mant = mant; v.ex = ex; v.sat = sat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    task automatic drive(input vec_t v);
        data_in = v.x; data_in_Q = v.dq; lnF_en = v.lnf_en; lnF_in = v.lnf;
        lnF_in_Q = v.lq; d_in = v.d; tag_in = v.tag;
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_valid"}, 64'(out_valid), 64'(0));
        chk({pfx, "_mant"}, mant_out, 64'(0));
        chk({pfx, "_exp"}, 64'(exp_out), 64'(0));
        chk({pfx, "_sat"}, 64'(sat_out), 64'(0));
        chk({pfx, "_tag"}, 64'(tag_out), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          k, sent, cyc;
        logic        acc;
        logic [3:0]  got_tags[$];

        // lanes packed {lane3, lane2, lane1, lane0}
        vecs[0] = mk(64'd0, 5'd8, 1'b0, 16'd0, 5'd0, 16'd0, 4'd1,
                     {4{16'd4096}}, 24'd0, 4'b0000);
        vecs[1] = mk({16'd0, 16'd0, -16'sd256, 16'sd256}, 5'd8, 1'b0, 16'd0, 5'd0, 16'd0, 4'd2,
                     {16'd4096, 16'd4096, 16'd6400, 16'd5888}, {6'd0, 6'd0, -6'sd2, 6'sd1}, 4'b0000);
        vecs[2] = mk({4{16'sd256}}, 5'd8, 1'b1, 16'd128, 5'd7, 16'd0, 4'd3,
                     {4{16'd4096}}, 24'd0, 4'b0000);
        vecs[3] = mk({4{16'sd256}}, 5'd8, 1'b1, 16'd128, 5'd7, -16'sd5000, 4'd4,
                     64'd0, 24'd0, 4'b1111);
        vecs[4] = mk({16'sd16, 16'h8000, 16'd0, 16'sd32767}, 5'd4, 1'b0, 16'd0, 5'd0, 16'd0, 4'd5,
                     {16'd5888, 16'd4096, 16'd4096, 16'd7936}, {6'sd1, 6'h20, 6'd0, 6'sd31}, 4'b0101);
        vecs[5] = mk({16'd0, 16'sd32767, -16'sd1, 16'sd16384}, 5'd16, 1'b0, 16'd0, 5'd0, 16'd0, 4'd6,
                     {16'd4096, 16'd7039, 16'd8191, 16'd5568}, {6'd0, 6'd0, -6'sd1, 6'd0}, 4'b0000);
        vecs[6] = mk({-16'sd100, 16'sd100, -16'sd3, 16'sd3}, 5'd0, 1'b0, 16'd0, 5'd0, 16'd1000, 4'd7,
                     {4{16'd5096}}, {6'h20, 6'sd31, -6'sd4, 6'sd4}, 4'b1100);
        vecs[7] = mk({-16'sd256, 16'd0, 16'sd768, 16'sd512}, 5'd8, 1'b1, 16'd3, 5'd0, 16'd0, 4'd8,
                     {16'd5120, 16'd6912, 16'd4096, 16'd6400}, {-6'sd6, -6'sd5, 6'd0, -6'sd2}, 4'b0000);
        vecs[8] = mk({-16'sd1, 16'd0, 16'sd2, 16'sd1}, 5'd0, 1'b1, 16'd128, 5'd8, 16'd0, 4'd9,
                     {16'd7552, 16'd5248, 16'd4736, 16'd7040}, {-6'sd3, -6'sd1, 6'sd2, 6'd0}, 4'b0000);

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        data_in = '0; data_in_Q = '0; lnF_en = 1'b0; lnF_in = '0; lnF_in_Q = '0;
        d_in = '0; tag_in = '0;
        repeat (2) @(negedge clk);
        #1;
        chk_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'(1));

        // Table: one beat at a time, full output word compared.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            k = 0;
            while (!out_valid && k < 8) begin
                @(negedge clk);
                k++;
            end
            #1;
            chk($sformatf("v%0d_mant", i), mant_out, vecs[i].mant);
            chk($sformatf("v%0d_exp", i), 64'(exp_out), 64'(vecs[i].ex));
            chk($sformatf("v%0d_sat", i), 64'(sat_out), 64'(vecs[i].sat));
            chk($sformatf("v%0d_tag", i), 64'(tag_out), 64'(vecs[i].tag));
        end

        // Stream of 8 tagged beats with a 5-cycle downstream stall.
        @(negedge clk);
        sent = 0;
        cyc = 0;
        got_tags.delete();
        while (sent < 8 && cyc < 100) begin
            if (cyc > 0) @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 8);
            in_valid = 1'b1;
            tag_in = 4'(sent);
            data_in = {48'd0, 16'(sent * 256)};
            data_in_Q = 5'd8; lnF_en = 1'b0; d_in = '0;
            #1;
            if (out_valid && out_ready) got_tags.push_back(tag_out);
            if (!out_ready) begin
                chk("stall_in_ready", 64'(in_ready), 64'(0));
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_tag", 64'(tag_out), 64'(1));
                chk("stall_mant", mant_out, {16'd4096, 16'd4096, 16'd4096, 16'd5888});
                chk("stall_exp", 64'(exp_out), 64'({6'd0, 6'd0, 6'd0, 6'sd1}));
            end
            acc = in_ready;
            @(posedge clk);
            if (acc) sent++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (got_tags.size() < 8 && cyc < 20) begin
            #1;
            if (out_valid) got_tags.push_back(tag_out);
            @(negedge clk);
            cyc++;
        end
        chk("stream_count", 64'(got_tags.size()), 64'(8));
        for (int i = 0; i < 8; i++) begin
            if (i < got_tags.size()) chk($sformatf("stream_tag%0d", i), 64'(got_tags[i]), 64'(i));
        end

        // Flush with three beats in flight; a beat offered in the flush cycle is dropped.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            tag_in = 4'(10 + i);
            data_in = '0;
        end
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        tag_in = 4'd13;
        #1;
        chk("flush_pre_valid", 64'(out_valid), 64'(1));
        chk("flush_pre_tag", 64'(tag_out), 64'(10));
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_valid", 64'(out_valid), 64'(0));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("flush_quiet", 64'(out_valid), 64'(0));
        end
        @(negedge clk);
        in_valid = 1'b1;
        tag_in = 4'd14;
        k = 0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            k = i;
            if (out_valid) break;
        end
        chk("flush_latency", 64'(k), 64'(3));
        chk("flush_new_tag", 64'(tag_out), 64'(14));

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            tag_in = 4'(1 + i);
            data_in = {4{16'sd256}};
            data_in_Q = 5'd8;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("prerst_valid", 64'(out_valid), 64'(1));
        chk("prerst_tag", 64'(tag_out), 64'(3));
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("postrst_quiet", 64'(out_valid), 64'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sfu_exp_pipe.md
Name: sfu_exp_pipe

Overview:
- Multi-lane, parametrised exponential unit for the SFU softmax/activation path.
- Per lane it computes e^(x - lnF) ≈ 2^u * (1 + v + d), where u is the integer part and v the fractional part of (x - lnF)*log2e.
- Output is a mantissa/exponent pair per lane, with saturation flags.
- It is the pipelined successor of the single-lane exp stage: LANES lanes, valid/ready back-pressure, synchronous flush, tag sideband, fixed-width output normalisation.

Parameters:
LANES, 4, number of parallel lanes sharing one control word
IN_W, 16, signed input width per lane
LNF_W, 16, signed lnF width
TMP_W, 32, signed internal width (TMP_W >= IN_W+LNF_W/2+8 required)
D_W, 16, signed correction term width, Q(FRAC_W)
FRAC_W, 12, output mantissa fraction bits
OUT_W, 16, unsigned output mantissa width (OUT_W > FRAC_W+1)
EXP_W, 6, signed output exponent width
TAG_W, 4, sideband tag width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline clear
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid & in_ready
data_in  in  LANES*IN_W  packed signed inputs, lane 0 in LSBs
data_in_Q  in  5  fractional bits of all data_in lanes (0..31)
lnF_en  in  1  1 = subtract lnF (second pass)
lnF_in  in  LNF_W  signed lnF
lnF_in_Q  in  5  fractional bits of lnF_in
d_in  in  D_W  signed correction term, Q(FRAC_W), shared across lanes
tag_in  in  TAG_W  sideband, passed through unchanged
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
mant_out  out  LANES*OUT_W  unsigned mantissa, Q(FRAC_W)
exp_out  out  LANES*EXP_W  signed exponent
sat_out  out  LANES  per-lane saturation (exponent or mantissa clamped)
tag_out  out  TAG_W  tag of the current output beat

Behaviour:
- Reset: all stage valids 0, all data/tag registers 0. out_valid=0, mant_out=0, exp_out=0, sat_out=0, tag_out=0.
- Pipeline is 3 register stages: S1 align/subtract, S2 log2e scale, S3 split/normalise/clamp. Outputs are driven from S3 registers.
- Latency is 3 cycles from accept to out_valid when there is no stall. Throughput is 1 beat/cycle.
- Global enable: en = ~out_valid | out_ready; in_ready = en. When en=0 all stages hold, and in_valid without in_ready is not captured. Stage valids shift only when en=1.
- Control (Q values, lnF_en, lnF_in, d_in, tag_in) is captured with the beat and travels with it. Beats with different Q values may be adjacent.
- S1:
  - If lnF_en=1: q = max(data_in_Q, lnF_in_Q); t = (x << (q - data_in_Q)) - (lnF << (q - lnF_in_Q)), sign-extended to TMP_W.
  - If lnF_en=0: t = sext(x); q = data_in_Q.
- S2: s = t + (t>>>1) - (t>>>4), all arithmetic shifts, TMP_W wide. This gives a 1.4375 approximation of log2e.
- S3 split:
  - u = s >>> q (floor toward -inf).
  - v = s - (u << q), so 0 <= v < 2^q.
  - vf = v >> (q - FRAC_W) if q >= FRAC_W, else v << (FRAC_W - q).
  - m = 2^FRAC_W + vf + sext(d_in), computed signed.
- S3 clamp:
  - exp_out = u clamped to [-2^(EXP_W-1), 2^(EXP_W-1)-1].
  - mant_out = m clamped to [0, 2^OUT_W-1].
  - sat_out[lane] = 1 if either clamp is active for that lane.
- flush: when asserted, clears all stage valids next edge (out_valid=0) regardless of en. Data registers are not cleared. in_ready follows the en rule in the same cycle. A beat accepted in the flush cycle is discarded.
- Reset mid-operation discards all in-flight beats; no partial output.
- While out_valid=1 & out_ready=0, every output signal is held stable.

Test Plan:
- Defaults, lnF_en=0, Q=8, d=0, all lanes x=0 -> after 3 cycles mant=4096, exp=0, sat=0.
- Lane0 x=256, lane1 x=-256, Q=8, d=0:
  - lane0 -> s=368, mant=5888, exp=1.
  - lane1 -> s=-368, mant=6400, exp=-2, sat=0.
- lnF_en=1, x=256 Q8, lnF=128 Q7 -> t=0, mant=4096, exp=0. Same beat with d=-5000 -> mant=0, sat=1.
- x=32767 Q4 -> s=47103, u=2943 clamped to exp=31, mant=7936, sat=1.
- Stream 8 beats with distinct tags:
  - Hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 while stalled; outputs held stable.
  - All 8 tags emerge in order with no loss or duplication.
- Assert flush with 3 beats in flight -> out_valid=0 next cycle; a subsequent beat emerges 3 cycles after acceptance. Pulse rst_n low mid-stream -> all outputs 0 asynchronously.
